// File: rtl/axis_delta_sigma_input_pkg.sv
// Shared defaults and helpers for the delta-sigma AXIS capture block.
//   DEF_DATA_WIDTH  : default tdata width
//   DEF_DEC_LEN     : default number of modulator bits per output word
//   DEF_SYNC_STAGES : default synchronizer depth
//   cnt_width()     : width of the in-window bit counter for a given DEC_LEN
`timescale 1ns/1ps
package axis_ds_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_DEC_LEN     = 255;
    localparam int DEF_SYNC_STAGES = 2;

    // Counter only needs to reach DEC_LEN-1 before wrapping.
    function automatic int cnt_width(input int dec_len);
        return $clog2(dec_len);
    endfunction

endpackage

// File: rtl/axis_delta_sigma_input_if.sv
// AXI4-Stream bus carrying decimated words (no tlast/tkeep).
//   tvalid : word present (master -> slave)
//   tready : slave can accept (slave -> master)
//   tdata  : ones count of one window (master -> slave)
// Handshake: a word transfers on every rising clock edge where tvalid and
// tready are both 1. Once tvalid is raised, it and tdata stay unchanged until
// that transfer happens; tready may change freely.
`timescale 1ns/1ps
interface axis_delta_sigma_input_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_delta_sigma_input_edge_sync.sv
// ds_edge_sync: brings the modulator clock and data into the aclk domain.
//   clk_i        : system clock (aclk)
//   rst_ni       : synchronous active-low reset
//   ds_clk_i     : asynchronous modulator bit clock
//   ds_data_i    : modulator bit, stable around ds_clk_i rising edge
//   sample_stb_o : one-cycle pulse, SYNC_STAGES+1 cycles after a ds_clk_i rise
//   sample_bit_o : modulator bit belonging to that pulse
`timescale 1ns/1ps
module ds_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ds_clk_i,
    input  logic ds_data_i,
    output logic sample_stb_o,
    output logic sample_bit_o
);

    // Clock and data go through chains of equal depth so the data sampled at
    // the detected edge is the bit the modulator presented at its rising edge.
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    logic                   stb_q;
    logic                   bit_q;
    logic                   stb_d;
    logic                   bit_d;

    always_comb begin
        stb_d = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
        bit_d = data_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            clk_prev_q  <= 1'b0;
            stb_q       <= 1'b0;
            bit_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ds_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ds_data_i};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
            stb_q       <= stb_d;
            bit_q       <= bit_d;
        end
    end

    assign sample_stb_o = stb_q;
    assign sample_bit_o = bit_q;

endmodule

// File: rtl/axis_delta_sigma_input.sv
// axis_delta_sigma_input: sinc1 decimator for a 1-bit delta-sigma stream.
// Counts ones over contiguous DEC_LEN-bit windows and presents each count as
// one AXI4-Stream word through a single-entry output register.
//   m_axis_aclk    : system clock, rising edge
//   m_axis_aresetn : synchronous active-low reset
//   ds_clk_i       : modulator bit clock (async, <= aclk/4)
//   ds_data_i      : modulator bit
//   enable         : 1 = acquire, 0 = keep the decimator cleared
//   m_axis         : AXIS master (tvalid/tready/tdata)
`timescale 1ns/1ps
module axis_delta_sigma_input
    import axis_ds_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DEC_LEN     = DEF_DEC_LEN,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                     m_axis_aclk,
    input  logic                     m_axis_aresetn,
    input  logic                     ds_clk_i,
    input  logic                     ds_data_i,
    input  logic                     enable,
    axis_delta_sigma_input_if.master m_axis
);

    localparam int CNT_W = cnt_width(DEC_LEN);

    logic                  sample_stb;
    logic                  sample_bit;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;

    logic                  take;
    logic                  last;
    logic                  out_free;
    logic [DATA_WIDTH-1:0] result;

    ds_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk_i        (m_axis_aclk),
        .rst_ni       (m_axis_aresetn),
        .ds_clk_i     (ds_clk_i),
        .ds_data_i    (ds_data_i),
        .sample_stb_o (sample_stb),
        .sample_bit_o (sample_bit)
    );

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;

        take     = sample_stb & enable;
        last     = take && (cnt_q == CNT_W'(DEC_LEN - 1));
        // DEC_LEN <= 2**DATA_WIDTH-1, so the sum including the last bit fits.
        result   = acc_q + DATA_WIDTH'(sample_bit);
        // Output slot is free when empty or being emptied this very cycle.
        out_free = !tvalid_q || m_axis.tready;

        if (!enable) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (take) begin
            if (last) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = result;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A finished window that finds the slot occupied is dropped so that
        // the pending word stays stable.
        if (last && out_free) begin
            tdata_d  = result;
            tvalid_d = 1'b1;
        end else if (tvalid_q && m_axis.tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;

endmodule

// File: tb/tb_axis_delta_sigma_input.sv
`timescale 1ns/1ps
module tb_axis_delta_sigma_input;

    localparam int      W    = 8;
    localparam realtime HALF = 104.0;  // ds_clk about 4.8 MHz

    // clock / reset
    logic aclk;
    logic aresetn;
    logic ds_clk;
    logic ds_data;
    logic en8;
    logic en255;

    initial aclk = 1'b0;
    always #2.5 aclk = ~aclk;

    axis_delta_sigma_input_if #(.DATA_WIDTH(W)) if8 ();
    axis_delta_sigma_input_if #(.DATA_WIDTH(W)) if255 ();

    axis_delta_sigma_input #(.DATA_WIDTH(W), .DEC_LEN(8), .SYNC_STAGES(2)) dut8 (
        .m_axis_aclk    (aclk),
        .m_axis_aresetn (aresetn),
        .ds_clk_i       (ds_clk),
        .ds_data_i      (ds_data),
        .enable         (en8),
        .m_axis         (if8)
    );

    axis_delta_sigma_input #(.DATA_WIDTH(W), .DEC_LEN(255), .SYNC_STAGES(2)) dut255 (
        .m_axis_aclk    (aclk),
        .m_axis_aresetn (aresetn),
        .ds_clk_i       (ds_clk),
        .ds_data_i      (ds_data),
        .enable         (en255),
        .m_axis         (if255)
    );

    // scoreboard
    logic [W-1:0] exp_q8[$];
    logic [W-1:0] exp_q255[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Handshake happens at the next rising edge; sample on the falling edge.
    always @(negedge aclk) begin
        if (aresetn === 1'b1 && if8.tvalid === 1'b1 && if8.tready === 1'b1) begin
            n_checks++;
            assert (exp_q8.size() != 0) else begin
                n_errors++;
                $error("FAIL word8_unexpected got=%0d exp=none", if8.tdata);
            end
            if (exp_q8.size() != 0) begin
                logic [W-1:0] e;
                e = exp_q8.pop_front();
                n_checks++;
                assert (if8.tdata === e) else begin
                    n_errors++;
                    $error("FAIL word8 got=%0d exp=%0d", if8.tdata, e);
                end
            end
        end
    end

    always @(negedge aclk) begin
        if (aresetn === 1'b1 && if255.tvalid === 1'b1 && if255.tready === 1'b1) begin
            n_checks++;
            assert (exp_q255.size() != 0) else begin
                n_errors++;
                $error("FAIL word255_unexpected got=%0d exp=none", if255.tdata);
            end
            if (exp_q255.size() != 0) begin
                logic [W-1:0] e;
                e = exp_q255.pop_front();
                n_checks++;
                assert (if255.tdata === e) else begin
                    n_errors++;
                    $error("FAIL word255 got=%0d exp=%0d", if255.tdata, e);
                end
            end
        end
    end

    // driver tasks
    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge aclk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ds_data = b;
        #(HALF) ds_clk = 1'b1;
        #(HALF) ds_clk = 1'b0;
    endtask

    task automatic send_n(input int n, input logic b);
        for (int i = 0; i < n; i++) send_bit(b);
    endtask

    initial begin
        logic [7:0] pat;
        aresetn    = 1'b0;
        ds_clk     = 1'b0;
        ds_data    = 1'b0;
        en8        = 1'b0;
        en255      = 1'b0;
        if8.tready   = 1'b1;
        if255.tready = 1'b1;

        // 1. reset and idle with ds_clk stopped
        wait_cycles(2);
        for (int i = 0; i < 8; i++) begin
            check("rst_tvalid8", 32'(if8.tvalid), 32'd0);
            check("rst_tdata8", 32'(if8.tdata), 32'd0);
            check("rst_tvalid255", 32'(if255.tvalid), 32'd0);
            wait_cycles(1);
        end
        aresetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("idle_tvalid8", 32'(if8.tvalid), 32'd0);
            check("idle_tdata8", 32'(if8.tdata), 32'd0);
            check("idle_tvalid255", 32'(if255.tvalid), 32'd0);
            check("idle_tdata255", 32'(if255.tdata), 32'd0);
            wait_cycles(1);
        end

        // 2. all ones through DEC_LEN=255, tready held high
        en255 = 1'b1;
        exp_q255.push_back(8'd255);
        exp_q255.push_back(8'd255);
        send_n(510, 1'b1);
        wait_cycles(8);
        check("dl255_drained", 32'(exp_q255.size()), 32'd0);
        check("dl255_idle", 32'(if255.tvalid), 32'd0);
        en255 = 1'b0;

        // 3. alternating pattern with strobe latency check, then all zeros
        en8 = 1'b1;
        exp_q8.push_back(8'd4);
        @(posedge aclk);
        #1;
        ds_data = 1'b1;
        ds_clk  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge aclk);
            #1;
            check("stb_latency", 32'(dut8.sample_stb), (k == 3) ? 32'd1 : 32'd0);
        end
        #(HALF) ds_clk = 1'b0;
        #(HALF);
        for (int i = 1; i < 8; i++) send_bit(i[0] ? 1'b0 : 1'b1);
        exp_q8.push_back(8'd0);
        send_n(8, 1'b0);
        wait_cycles(8);
        check("alt_zero_drained", 32'(exp_q8.size()), 32'd0);

        // 4. backpressure across three windows of ones
        if8.tready = 1'b0;
        exp_q8.push_back(8'd8);
        for (int w = 0; w < 3; w++) begin
            send_n(8, 1'b1);
            wait_cycles(8);
            check("bp_tvalid", 32'(if8.tvalid), 32'd1);
            check("bp_tdata", 32'(if8.tdata), 32'd8);
        end
        @(posedge aclk);
        #1;
        if8.tready = 1'b1;
        wait_cycles(3);
        check("bp_drop_tvalid", 32'(if8.tvalid), 32'd0);
        check("bp_single_word", 32'(exp_q8.size()), 32'd0);
        exp_q8.push_back(8'd8);
        send_n(8, 1'b1);
        wait_cycles(8);
        check("bp_next_word", 32'(exp_q8.size()), 32'd0);

        // 5. enable dropped mid-window
        send_n(5, 1'b1);
        en8 = 1'b0;
        send_n(3, 1'b1);
        en8 = 1'b1;
        pat = 8'b1011_1011;
        exp_q8.push_back(8'd6);
        for (int i = 0; i < 8; i++) send_bit(pat[i]);
        wait_cycles(8);
        check("enable_word", 32'(exp_q8.size()), 32'd0);

        // 6. reset mid-window with a word pending
        if8.tready = 1'b0;
        send_n(8, 1'b1);
        wait_cycles(8);
        check("pend_tvalid", 32'(if8.tvalid), 32'd1);
        send_n(3, 1'b1);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        wait_cycles(1);
        check("midrst_tvalid", 32'(if8.tvalid), 32'd0);
        check("midrst_tdata", 32'(if8.tdata), 32'd0);
        aresetn = 1'b1;
        if8.tready = 1'b1;
        exp_q8.push_back(8'd8);
        send_n(8, 1'b1);
        wait_cycles(8);
        check("post_rst_word", 32'(exp_q8.size()), 32'd0);
        check("post_rst_idle", 32'(if8.tvalid), 32'd0);
        check("q255_empty", 32'(exp_q255.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
